// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer for KGP-RISC: owns the PC, issues BRAM reads,
// absorbs the one-cycle read latency with a skid entry and presents a valid/ready stream.
module fetch_sequencer #(
    parameter int          ADDR_W    = 5,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_rdata,
    output logic              inst_valid,
    output logic [31:0]       inst,
    output logic [31:0]       inst_pc,
    input  logic              inst_ready,
    output logic [31:0]       fetch_pc,
    output logic              halted
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_HALT
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [31:0] r_fetch_pc;
    logic        r_pend;
    logic [31:0] r_pend_pc;
    logic        r_skid_valid;
    logic [31:0] r_skid_inst;
    logic [31:0] r_skid_pc;
    logic        r_inst_valid;
    logic [31:0] r_inst;
    logic [31:0] r_inst_pc;
    logic        r_halted;

    logic        w_accept;
    logic        w_halt_acc;
    logic        w_redirect;
    logic        w_issue;
    logic        w_out_free;
    logic        w_unused;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Halt beats redirect; an issue is held off whenever the returning word could find no free slot.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = r_inst_valid & inst_ready;
        w_halt_acc  = (r_state == S_FETCH) & w_accept & (r_inst == HALT_WORD);
        w_redirect  = (r_state == S_FETCH) & redirect_valid & !w_halt_acc;
        w_issue     = (r_state == S_FETCH) & !r_skid_valid
                      & !(r_pend & r_inst_valid & !inst_ready) & !redirect_valid;
        w_out_free  = !r_inst_valid | inst_ready;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_FETCH;
            S_FETCH: if (w_halt_acc) w_state_nxt = S_HALT;
            S_HALT:  w_state_nxt = S_HALT;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fetch_pc   <= RESET_PC;
            r_pend       <= 1'b0;
            r_pend_pc    <= 32'h0;
            r_skid_valid <= 1'b0;
            r_skid_inst  <= 32'h0;
            r_skid_pc    <= 32'h0;
            r_inst_valid <= 1'b0;
            r_inst       <= 32'hFFFF_FFFF;
            r_inst_pc    <= 32'h0;
            r_halted     <= 1'b0;
        end else begin
            if (w_issue) begin
                r_pend_pc  <= r_fetch_pc;
                r_fetch_pc <= r_fetch_pc + 32'd4;
            end
            if (w_halt_acc) begin
                r_pend       <= 1'b0;
                r_skid_valid <= 1'b0;
                r_inst_valid <= 1'b0;
                r_halted     <= 1'b1;
            end else if (w_redirect) begin
                r_pend       <= 1'b0;
                r_skid_valid <= 1'b0;
                r_inst_valid <= 1'b0;
                r_fetch_pc   <= {redirect_pc[31:2], 2'b00};
            end else begin
                r_pend <= w_issue;
                // The skid always drains first so issue order is preserved.
                if (w_out_free) begin
                    if (r_skid_valid) begin
                        r_inst       <= r_skid_inst;
                        r_inst_pc    <= r_skid_pc;
                        r_inst_valid <= 1'b1;
                        r_skid_valid <= r_pend;
                    end else if (r_pend) begin
                        r_inst       <= mem_rdata;
                        r_inst_pc    <= r_pend_pc;
                        r_inst_valid <= 1'b1;
                    end else begin
                        r_inst_valid <= 1'b0;
                    end
                end else if (r_pend) begin
                    r_skid_valid <= 1'b1;
                end
                if (r_pend & (r_skid_valid | !w_out_free)) begin
                    r_skid_inst <= mem_rdata;
                    r_skid_pc   <= r_pend_pc;
                end
            end
        end
    end

    assign mem_en     = w_issue;
    assign mem_addr   = r_fetch_pc[ADDR_W+1:2];
    assign inst_valid = r_inst_valid;
    assign inst       = r_inst;
    assign inst_pc    = r_inst_pc;
    assign fetch_pc   = r_fetch_pc;
    assign halted     = r_halted;
    assign w_unused   = ^redirect_pc[1:0];

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Controls the instruction BRAM for KGP-RISC fetch. Owns the PC and drives the BRAM address and enable.
- Absorbs the BRAM's one-cycle read latency through a one-entry skid buffer.
- Presents instructions downstream with a valid/ready handshake.
- Handles branch redirects and stops fetch permanently on the all-ones halt word.

Parameters:
ADDR_W, 5, BRAM word-address width; mem_addr = pc[ADDR_W+1:2]
RESET_PC, 32'h0000_0000, PC loaded at reset
HALT_WORD, 32'hFFFF_FFFF, instruction encoding that halts fetch

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  leave IDLE and begin fetching at fetch_pc
redirect_valid  in  1  branch/jump taken; flush and refetch
redirect_pc  in  32  redirect target; bits [1:0] forced to 0
mem_en  out  1  BRAM read enable (issue strobe)
mem_addr  out  ADDR_W  BRAM word address = fetch_pc[ADDR_W+1:2]
mem_rdata  in  32  BRAM data, valid the cycle after an issue
inst_valid  out  1  inst/inst_pc hold a valid instruction
inst  out  32  presented instruction
inst_pc  out  32  byte PC of inst
inst_ready  in  1  downstream accepts inst this cycle
fetch_pc  out  32  PC of the next issue
halted  out  1  sticky halt indication

Behaviour:
- Reset (rst low, asynchronous) values:
  - state = IDLE, fetch_pc = RESET_PC.
  - inst_valid = 0, inst = 32'hFFFF_FFFF, inst_pc = 0.
  - halted = 0, pend = 0, skid_valid = 0.
  - mem_en = 0 while rst is low.
- States: IDLE, FETCH, HALT.
  - IDLE -> FETCH when start is sampled high.
  - FETCH -> HALT when an accept (inst_valid & inst_ready) has inst == HALT_WORD.
  - HALT is exited only by reset. start and redirect are ignored in HALT.
- Issue condition (combinational), mem_en = FETCH & !skid_valid & !(pend & inst_valid & !inst_ready) & !redirect_valid.
- On each issue: pend <= 1, pend_pc <= fetch_pc, fetch_pc <= fetch_pc + 4 (32-bit wrap). mem_addr wraps naturally inside the ROM.
- Return path: on the cycle after an issue (pend = 1), mem_rdata/pend_pc are routed as follows:
  - into the output register if it is empty or being accepted and the skid is empty;
  - otherwise into the skid.
- Skid drain: when the output register is free (empty or accepted) and skid_valid = 1, the skid moves to the output register first. A returning word then goes to the skid.
- Ordering: instructions are presented strictly in issue order; at most 2 instructions are held (output + skid).
- Throughput: with inst_ready held high, one instruction per cycle.
- Latency:
  - start sampled at edge E0, first mem_en in the cycle after E0, first inst_valid after E2.
  - After a redirect edge, the first target instruction is valid 2 edges later.
- Redirect (FETCH only, highest priority):
  - If it coincides with inst_ready, that handshake still completes.
  - The same edge clears inst_valid, skid_valid and pend; the in-flight BRAM data is discarded.
  - fetch_pc <= {redirect_pc[31:2], 2'b00}.
  - No issue occurs in the redirect cycle.
- Halt:
  - On the halt accept, pend and skid_valid are cleared and halted <= 1.
  - No further mem_en, and inst_valid stays 0.
  - Halt has priority over a simultaneous redirect.
- Output stability: inst and inst_pc do not change while inst_valid = 1 and inst_ready = 0.
- mem_en is never asserted in IDLE or HALT.
- Reset mid-operation: all state is dropped immediately on rst falling. There is no output glitch beyond the reset values.

Test Plan:
- Sequential fetch:
  - Stimulus: ROM[0..3] = 0x11,0x22,0x33,0xFFFFFFFF, reset, start pulse, inst_ready = 1.
  - Required: inst 0x11/0x22/0x33 on consecutive cycles with inst_pc 0,4,8; halted = 1 after the 4th accept; no mem_en afterwards.
- Backpressure:
  - Stimulus: inst_ready low for 5 cycles after the first inst_valid.
  - Required: inst holds 0x11 @ pc 0; mem_en drops once the skid is full; after ready rises, 0x22, 0x33 follow with no loss or duplication.
- Redirect:
  - Stimulus: redirect_valid with redirect_pc = 0x13 while 0x22 is pending.
  - Required: 0x22 never presented; fetch_pc = 0x10; next inst = ROM[4] @ inst_pc 0x10 two edges later.
- Redirect with accept:
  - Stimulus: redirect_valid and inst_ready in the same cycle.
  - Required: the current inst is counted accepted, the skid is flushed, and fetch restarts at the target.
- Async reset:
  - Stimulus: drop rst mid-fetch between clock edges.
  - Required: inst_valid = 0, mem_en = 0, fetch_pc = RESET_PC immediately; IDLE until the next start.
- Wrap:
  - Stimulus: redirect_pc = 0x7C (ADDR_W = 5).
  - Required: mem_addr 31 then 0; inst_pc 0x7C then 0x80.
